// File: rtl/wasm_pkg.sv
// rtl/wasm_pkg.sv - shared constants and enums for the wasm section scanner
package wasm_pkg;

  // Header bytes, byte 0 in bits [7:0]
  localparam logic [31:0] MAGIC_WORD   = 32'h6D73_6100;
  localparam logic [31:0] VERSION_WORD = 32'h0000_0001;

  localparam logic [3:0] SEC_CUSTOM    = 4'd0;
  localparam logic [3:0] SEC_TYPE      = 4'd1;
  localparam logic [3:0] SEC_IMPORT    = 4'd2;
  localparam logic [3:0] SEC_FUNCTION  = 4'd3;
  localparam logic [3:0] SEC_TABLE     = 4'd4;
  localparam logic [3:0] SEC_MEMORY    = 4'd5;
  localparam logic [3:0] SEC_GLOBAL    = 4'd6;
  localparam logic [3:0] SEC_EXPORT    = 4'd7;
  localparam logic [3:0] SEC_START     = 4'd8;
  localparam logic [3:0] SEC_ELEMENT   = 4'd9;
  localparam logic [3:0] SEC_CODE      = 4'd10;
  localparam logic [3:0] SEC_DATA      = 4'd11;
  localparam logic [3:0] SEC_DATACOUNT = 4'd12;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_MAGIC   = 3'd1,
    ERR_VERSION = 3'd2,
    ERR_BAD_ID  = 3'd3,
    ERR_ORDER   = 3'd4,
    ERR_LEB     = 3'd5,
    ERR_TRUNC   = 3'd6
  } err_code_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MAGIC,
    ST_VERSION,
    ST_CHECK_END,
    ST_SEC_ID,
    ST_SEC_LEN,
    ST_SKIP,
    ST_DONE,
    ST_ERROR
  } scan_state_e;

endpackage

// File: rtl/leb128_u32_dec.sv
// rtl/leb128_u32_dec.sv - byte-serial unsigned LEB128 decoder into 32 bits
module leb128_u32_dec #(
  parameter int LEB_MAX = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  input  logic        i_clear,
  output logic [31:0] o_value,
  output logic        o_last,
  output logic        o_overflow
);

  logic [3:0]  r_k;
  logic [31:0] r_value;
  logic [31:0] w_shift;
  logic [31:0] w_chunk;
  logic        w_fit_bad;

  // Payload bits of the current byte that would land above bit 31
  always_comb begin
    w_shift   = 32'(r_k) * 32'd7;
    w_chunk   = {25'd0, i_byte[6:0]};
    w_fit_bad = 1'b0;
    if (w_shift >= 32'd32) begin
      w_fit_bad = |i_byte[6:0];
    end else if (w_shift + 32'd7 > 32'd32) begin
      w_fit_bad = |(w_chunk >> (32'd32 - w_shift));
    end
  end

  assign o_last     = i_valid & ~i_byte[7];
  assign o_overflow = i_valid & (((r_k == 4'(LEB_MAX - 1)) & i_byte[7]) | w_fit_bad);
  assign o_value    = r_value;

  // Accumulate 7 bits per accepted byte, least significant group first
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_k     <= 4'd0;
      r_value <= 32'd0;
    end else if (i_valid) begin
      r_k     <= r_k + 4'd1;
      r_value <= r_value | (w_chunk << w_shift);
    end
  end

endmodule

// File: rtl/wasm_section_scanner.sv
// rtl/wasm_section_scanner.sv - wasm header check and section location table
module wasm_section_scanner
  import wasm_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int MAX_ID  = 12,
  parameter int LEB_MAX = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_mod_len,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [2:0]        o_err_code,
  input  logic [3:0]        i_q_id,
  output logic              o_q_present,
  output logic [ADDR_W-1:0] o_q_off,
  output logic [31:0]       o_q_len
);

  localparam int NUM_ENT = MAX_ID + 1;

  scan_state_e       r_state;
  scan_state_e       w_state_n;
  logic              r_phase;      // 0: issue read, 1: capture data
  logic [1:0]        r_cnt;        // header byte index within MAGIC/VERSION
  logic [32:0]       r_ptr;        // wide enough that ptr + section size never wraps
  logic [32:0]       r_end;
  logic [3:0]        r_cur_id;
  logic [3:0]        r_last_id;    // last non-zero id, for ordering
  logic              r_err;
  err_code_e         r_err_code;

  logic              r_present [NUM_ENT];
  logic [ADDR_W-1:0] r_off     [NUM_ENT];
  logic [31:0]       r_len     [NUM_ENT];

  logic              w_mem_rd;
  logic              w_err_set;
  err_code_e         w_err_code_n;
  logic [7:0]        w_hdr_byte;
  logic              w_leb_valid;
  logic              w_leb_clear;
  logic [31:0]       w_leb_value;
  logic              w_leb_last;
  logic              w_leb_ovf;
  logic              w_tbl_wr;

  leb128_u32_dec #(.LEB_MAX(LEB_MAX)) u_leb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_byte     (i_mem_data),
    .i_valid    (w_leb_valid),
    .i_clear    (w_leb_clear),
    .o_value    (w_leb_value),
    .o_last     (w_leb_last),
    .o_overflow (w_leb_ovf)
  );

  // Next state, read strobe and error detection
  always_comb begin
    w_state_n    = r_state;
    w_mem_rd     = 1'b0;
    w_err_set    = 1'b0;
    w_err_code_n = ERR_NONE;
    w_leb_valid  = 1'b0;
    w_leb_clear  = 1'b0;
    w_hdr_byte   = (r_state == ST_MAGIC) ? MAGIC_WORD[{r_cnt, 3'b000} +: 8]
                                         : VERSION_WORD[{r_cnt, 3'b000} +: 8];
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_n   = ST_MAGIC;
          w_leb_clear = 1'b1;
        end
      end
      ST_MAGIC, ST_VERSION: begin
        if (!r_phase) begin
          // Short module: stop before reading past its end
          if (r_ptr == r_end) begin
            w_err_set    = 1'b1;
            w_err_code_n = ERR_TRUNC;
          end else begin
            w_mem_rd = 1'b1;
          end
        end else if (i_mem_data != w_hdr_byte) begin
          w_err_set    = 1'b1;
          w_err_code_n = (r_state == ST_MAGIC) ? ERR_MAGIC : ERR_VERSION;
        end else if (r_cnt == 2'd3) begin
          w_state_n = (r_state == ST_MAGIC) ? ST_VERSION : ST_CHECK_END;
        end
      end
      ST_CHECK_END: begin
        w_leb_clear = 1'b1;
        if (r_ptr == r_end) begin
          w_state_n = ST_DONE;
        end else if (r_ptr > r_end) begin
          w_err_set    = 1'b1;
          w_err_code_n = ERR_TRUNC;
        end else begin
          w_state_n = ST_SEC_ID;
        end
      end
      ST_SEC_ID: begin
        if (!r_phase) begin
          w_mem_rd = 1'b1;
        end else if (i_mem_data > 8'(MAX_ID)) begin
          w_err_set    = 1'b1;
          w_err_code_n = ERR_BAD_ID;
        end else if ((i_mem_data[3:0] != SEC_CUSTOM) && (i_mem_data[3:0] <= r_last_id)) begin
          w_err_set    = 1'b1;
          w_err_code_n = ERR_ORDER;
        end else begin
          w_state_n = ST_SEC_LEN;
        end
      end
      ST_SEC_LEN: begin
        if (!r_phase) begin
          w_mem_rd = 1'b1;
        end else begin
          w_leb_valid = 1'b1;
          if (w_leb_ovf) begin
            w_err_set    = 1'b1;
            w_err_code_n = ERR_LEB;
          end else if (w_leb_last) begin
            w_state_n = ST_SKIP;
          end
        end
      end
      ST_SKIP:  w_state_n = ST_CHECK_END;
      ST_DONE:  w_state_n = ST_IDLE;
      ST_ERROR: w_state_n = ST_IDLE;
      default:  w_state_n = ST_IDLE;
    endcase
    if (w_err_set) begin
      w_state_n = ST_ERROR;
    end
  end

  // Repeated custom sections keep the location of the first one
  assign w_tbl_wr = (r_cur_id != SEC_CUSTOM) || !r_present[0];

  // State, pointer, error and table registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_phase    <= 1'b0;
      r_cnt      <= 2'd0;
      r_ptr      <= 33'd0;
      r_end      <= 33'd0;
      r_cur_id   <= 4'd0;
      r_last_id  <= 4'd0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      for (int i = 0; i < NUM_ENT; i++) begin
        r_present[i] <= 1'b0;
        r_off[i]     <= '0;
        r_len[i]     <= 32'd0;
      end
    end else begin
      r_state <= w_state_n;
      if (r_state == ST_IDLE && i_start) begin
        r_ptr      <= 33'(i_base_addr);
        r_end      <= 33'(i_base_addr) + 33'(i_mod_len);
        r_phase    <= 1'b0;
        r_cnt      <= 2'd0;
        r_last_id  <= 4'd0;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
        for (int i = 0; i < NUM_ENT; i++) begin
          r_present[i] <= 1'b0;
          r_off[i]     <= '0;
          r_len[i]     <= 32'd0;
        end
      end
      if (w_mem_rd) begin
        r_phase <= 1'b1;
      end
      if (r_phase) begin
        r_phase <= 1'b0;
        r_ptr   <= r_ptr + 33'd1;
        r_cnt   <= r_cnt + 2'd1;
      end
      if (r_state == ST_SEC_ID && r_phase) begin
        r_cur_id <= i_mem_data[3:0];
        if (i_mem_data[3:0] != SEC_CUSTOM) begin
          r_last_id <= i_mem_data[3:0];
        end
      end
      if (r_state == ST_SKIP) begin
        if (w_tbl_wr) begin
          r_present[r_cur_id] <= 1'b1;
          r_off[r_cur_id]     <= r_ptr[ADDR_W-1:0];
          r_len[r_cur_id]     <= w_leb_value;
        end
        r_ptr <= r_ptr + 33'(w_leb_value);
      end
      if (w_err_set) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code_n;
      end
    end
  end

  assign o_mem_rd    = w_mem_rd;
  assign o_mem_addr  = r_ptr[ADDR_W-1:0];
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;
  assign o_q_present = (i_q_id <= 4'(MAX_ID)) ? r_present[i_q_id] : 1'b0;
  assign o_q_off     = (i_q_id <= 4'(MAX_ID)) ? r_off[i_q_id] : '0;
  assign o_q_len     = (i_q_id <= 4'(MAX_ID)) ? r_len[i_q_id] : 32'd0;

endmodule

// File: tb/tb_wasm_section_scanner.sv
// tb/tb_wasm_section_scanner.sv - directed bench for wasm_section_scanner
module tb_wasm_section_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] mod_len = '0;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data = '0;
  logic        busy, done, err;
  logic [2:0]  err_code;
  logic [3:0]  q_id = '0;
  logic        q_present;
  logic [11:0] q_off;
  logic [31:0] q_len;

  logic [7:0]  mem [4096];
  logic        clr_watch = 1'b0;
  logic [11:0] max_rd = '0;

  int vectors = 0;
  int miscompares = 0;

  wasm_section_scanner dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_mod_len   (mod_len),
    .o_mem_rd    (mem_rd),
    .o_mem_addr  (mem_addr),
    .i_mem_data  (mem_data),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_err_code  (err_code),
    .i_q_id      (q_id),
    .o_q_present (q_present),
    .o_q_off     (q_off),
    .o_q_len     (q_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
    if (clr_watch) max_rd <= '0;
    else if (mem_rd && mem_addr > max_rd) max_rd <= mem_addr;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put_hdr(input int b);
    mem[b+0] = 8'h00; mem[b+1] = 8'h61; mem[b+2] = 8'h73; mem[b+3] = 8'h6D;
    mem[b+4] = 8'h01; mem[b+5] = 8'h00; mem[b+6] = 8'h00; mem[b+7] = 8'h00;
  endtask

  task automatic query(input int id);
    q_id = 4'(id);
    #1;
  endtask

  // Start a scan and wait for done/err; lat is the edge (from E0) at which the pulse is sampled
  task automatic run(input int b, input int len, input int poke,
                     output int lat, output bit got_done, output bit got_err);
    @(negedge clk);
    base_addr = 12'(b); mod_len = 13'(len); start = 1'b1; clr_watch = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr_watch = 1'b0;
    lat = 0; got_done = 1'b0; got_err = 1'b0;
    for (int k = 1; k <= 2000 && !got_done && !got_err; k++) begin
      @(posedge clk); #1;
      if (done) begin got_done = 1'b1; lat = k + 1; end
      if (err) begin got_err = 1'b1; lat = k + 1; end
      if (k == poke) begin start = 1'b1; base_addr = 12'd300; mod_len = 13'd5; end
      else start = 1'b0;
    end
    start = 1'b0;
    if (!got_done && !got_err) chk("timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int lat;
  bit gd, ge;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    query(1);
    chk("rst_q", {q_present, q_off, q_len}, 0);
    @(negedge clk); rst = 1'b0;

    // Minimal module
    put_hdr(0);
    run(0, 8, 0, lat, gd, ge);
    chk("min_done", gd, 1);
    chk("min_lat", lat, 18);
    for (int i = 0; i <= 12; i++) begin
      query(i);
      chk("min_absent", q_present, 0);
    end

    // One type section
    mem[8] = 8'h01; mem[9] = 8'h04;
    mem[10] = 8'hAA; mem[11] = 8'hBB; mem[12] = 8'hCC; mem[13] = 8'hDD;
    run(0, 14, 0, lat, gd, ge);
    chk("type_done", gd, 1);
    chk("type_lat", lat, 24);
    query(1);
    chk("type_present", q_present, 1);
    chk("type_off", q_off, 10);
    chk("type_len", q_len, 4);
    query(13);
    chk("q_above_max", q_present, 0);

    // Bad magic
    mem[2] = 8'h74;
    run(0, 14, 0, lat, gd, ge);
    chk("magic_err", {gd, ge}, 2'b01);
    chk("magic_code", err_code, 1);
    chk("magic_max_rd", max_rd, 2);
    mem[2] = 8'h73;

    // Code section with two-byte size at base 100
    put_hdr(100);
    mem[108] = 8'h0A; mem[109] = 8'h80; mem[110] = 8'h01;
    run(100, 139, 0, lat, gd, ge);
    chk("code_done", gd, 1);
    chk("code_err_cleared", err, 0);
    chk("code_lat", lat, 26);
    query(10);
    chk("code_off", q_off, 111);
    chk("code_len", q_len, 128);

    // Out of order: 03 then 01
    put_hdr(400);
    mem[408] = 8'h03; mem[409] = 8'h00; mem[410] = 8'h01; mem[411] = 8'h00;
    run(400, 12, 0, lat, gd, ge);
    chk("order_code", {gd, ge, err_code}, {2'b01, 3'd4});
    query(3);
    chk("order_kept_entry", {q_present, q_off}, {1'b1, 12'd410});

    // Over-long LEB
    put_hdr(500);
    mem[508] = 8'h01; mem[509] = 8'hFF; mem[510] = 8'hFF; mem[511] = 8'hFF;
    mem[512] = 8'hFF; mem[513] = 8'h7F;
    run(500, 14, 0, lat, gd, ge);
    chk("leb_code", {gd, ge, err_code}, {2'b01, 3'd5});

    // Size 20 with 10 payload bytes
    put_hdr(600);
    mem[608] = 8'h01; mem[609] = 8'h14;
    run(600, 20, 0, lat, gd, ge);
    chk("trunc_code", {gd, ge, err_code}, {2'b01, 3'd6});
    query(1);
    chk("trunc_entry_len", q_len, 20);

    // Module shorter than the header
    run(0, 5, 0, lat, gd, ge);
    chk("short_code", {gd, ge, err_code}, {2'b01, 3'd6});
    chk("short_max_rd", max_rd, 4);

    // Id above MAX_ID
    put_hdr(700);
    mem[708] = 8'h0D; mem[709] = 8'h00;
    run(700, 10, 0, lat, gd, ge);
    chk("badid_code", {gd, ge, err_code}, {2'b01, 3'd3});

    // Empty sections, repeated custom, last section exactly at end
    put_hdr(800);
    mem[808] = 8'h00; mem[809] = 8'h00;
    mem[810] = 8'h00; mem[811] = 8'h01; mem[812] = 8'h55;
    mem[813] = 8'h02; mem[814] = 8'h00;
    run(800, 15, 0, lat, gd, ge);
    chk("empty_done", gd, 1);
    chk("empty_lat", lat, 36);
    query(0);
    chk("custom_first", {q_present, q_off, q_len}, {1'b1, 12'd810, 32'd0});
    query(2);
    chk("empty_import", {q_present, q_off, q_len}, {1'b1, 12'd815, 32'd0});

    // Reset during VERSION
    @(negedge clk);
    base_addr = 12'd0; mod_len = 13'd14; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_rd", mem_rd, 0);
    query(2);
    chk("midrst_table", q_present, 0);

    // Rescan, with a start pulse injected while busy
    run(0, 14, 5, lat, gd, ge);
    chk("rescan_done", gd, 1);
    chk("rescan_lat", lat, 24);
    query(1);
    chk("rescan_off", {q_present, q_off, q_len}, {1'b1, 12'd10, 32'd4});
    chk("rescan_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
